// File: rtl/div_pkg.sv
// Shared constants, state encoding and sign helper for the iterative divider.
package div_pkg;

    localparam int WIDTH = 32;
    localparam int ITERS = 32;
    localparam int CNT_W = $clog2(ITERS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] DIV0_QUOTIENT = 32'hFFFF_FFFF;

    // Two's-complement negate when neg is set; used both to take magnitudes and to restore signs.
    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/div_trial_sub.sv
// Combinational trial subtractor A + ~B + 1 built from 4-bit carry-lookahead slices.
module div_trial_sub
#(
    parameter int W = 33
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-2:0] o_diff,
    output logic         o_neg
);

    localparam int SLICES = (W + 3) / 4;

    logic [W-1:0] w_nb;
    logic [W-1:0] w_g;
    logic [W-1:0] w_p;
    logic [W-1:0] w_sum;

    assign w_nb = ~i_b;
    assign w_g  = i_a & w_nb;
    assign w_p  = i_a ^ w_nb;

    // Carry into bit n of a slice as a flat sum of generate/propagate products.
    function automatic logic cla_carry(input logic ci, input logic [3:0] g,
                                       input logic [3:0] p, input int n);
        logic c;
        logic t;
        c = ci;
        for (int k = 0; k < n; k++) c = c & p[k];
        for (int m = 0; m < n; m++) begin
            t = g[m];
            for (int k = m + 1; k < n; k++) t = t & p[k];
            c = c | t;
        end
        return c;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < SLICES; gi++) begin : g_slice
            localparam int LO = gi * 4;
            localparam int SW = ((W - LO) < 4) ? (W - LO) : 4;

            logic       w_ci;
            logic [3:0] w_gs;
            logic [3:0] w_ps;

            assign w_gs = 4'(w_g[LO +: SW]);
            assign w_ps = 4'(w_p[LO +: SW]);

            if (gi == 0) begin : g_first
                assign w_ci = 1'b1;
            end else begin : g_chain
                assign w_ci = g_slice[gi-1].g_co.w_co;
            end

            genvar gj;
            for (gj = 0; gj < SW; gj++) begin : g_bit
                assign w_sum[LO+gj] = w_p[LO+gj] ^ cla_carry(w_ci, w_gs, w_ps, gj);
            end

            if (gi < SLICES - 1) begin : g_co
                logic w_co;
                assign w_co = cla_carry(w_ci, w_gs, w_ps, 4);
            end
        end
    endgenerate

    assign o_diff = w_sum[W-2:0];
    assign o_neg  = w_sum[W-1];

endmodule

// File: rtl/div_32.sv
// Iterative restoring divider: one quotient bit per cycle, signed or unsigned, fixed 33-cycle latency.
module div_32
#(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_is_signed,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder,
    output logic             o_div_by_zero
);

    import div_pkg::*;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_dvsr;
    logic [WIDTH-1:0] r_dividend;
    logic             r_q_neg;
    logic             r_r_neg;
    logic             r_div0;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_div_by_zero;

    logic [WIDTH:0]   w_trial_a;
    logic [WIDTH:0]   w_trial_b;
    logic [WIDTH-1:0] w_diff;
    logic             w_neg;
    logic [WIDTH-1:0] w_quot_next;
    logic [WIDTH-1:0] w_rem_next;
    logic             w_last;

    // The kept remainder is always below the divisor, so 32 bits hold it; the shift supplies bit 32.
    assign w_trial_a = {r_rem, r_quot[WIDTH-1]};
    assign w_trial_b = {1'b0, r_dvsr};

    div_trial_sub #(.W(WIDTH + 1)) u_trial_sub (
        .i_a    (w_trial_a),
        .i_b    (w_trial_b),
        .o_diff (w_diff),
        .o_neg  (w_neg)
    );

    assign w_quot_next = {r_quot[WIDTH-2:0], ~w_neg};
    assign w_rem_next  = w_neg ? w_trial_a[WIDTH-1:0] : w_diff;
    assign w_last      = (r_cnt == CNT_W'(ITERS - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_quot        <= '0;
            r_rem         <= '0;
            r_dvsr        <= '0;
            r_dividend    <= '0;
            r_q_neg       <= 1'b0;
            r_r_neg       <= 1'b0;
            r_div0        <= 1'b0;
            r_quotient    <= '0;
            r_remainder   <= '0;
            r_div_by_zero <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_state    <= CALC;
                        r_cnt      <= '0;
                        r_rem      <= '0;
                        r_quot     <= cond_neg(i_dividend, i_is_signed & i_dividend[WIDTH-1]);
                        r_dvsr     <= cond_neg(i_divisor, i_is_signed & i_divisor[WIDTH-1]);
                        r_dividend <= i_dividend;
                        r_q_neg    <= i_is_signed & (i_dividend[WIDTH-1] ^ i_divisor[WIDTH-1]);
                        r_r_neg    <= i_is_signed & i_dividend[WIDTH-1];
                        r_div0     <= (i_divisor == '0);
                    end
                end
                CALC: begin
                    r_quot <= w_quot_next;
                    r_rem  <= w_rem_next;
                    r_cnt  <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_state       <= DONE;
                        r_div_by_zero <= r_div0;
                        r_quotient    <= r_div0 ? DIV0_QUOTIENT : cond_neg(w_quot_next, r_q_neg);
                        r_remainder   <= r_div0 ? r_dividend : cond_neg(w_rem_next, r_r_neg);
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_busy        = (r_state != IDLE);
    assign o_done        = (r_state == DONE);
    assign o_quotient    = r_quotient;
    assign o_remainder   = r_remainder;
    assign o_div_by_zero = r_div_by_zero;

endmodule

// File: tb/tb_div_32.sv
// Directed-vector bench for div_32: latency, signed/unsigned results, divide-by-zero, abort and back-to-back.
module tb_div_32;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        is_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        dz;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    div_32 #(.WIDTH(32)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_start       (start),
        .i_is_signed   (is_signed),
        .i_dividend    (dividend),
        .i_divisor     (divisor),
        .o_busy        (busy),
        .o_done        (done),
        .o_quotient    (quotient),
        .o_remainder   (remainder),
        .o_div_by_zero (dz)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Holds start across one edge (cycle 0), then scrambles the operands; returns in cycle 1.
    task automatic launch(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        start     = 1'b1;
        is_signed = sgn;
        dividend  = a;
        divisor   = b;
        tick();
        start     = 1'b0;
        is_signed = ~sgn;
        dividend  = ~a;
        divisor   = 32'h0000_0003;
    endtask

    task automatic wait_done(input int from, output int cyc);
        cyc = from;
        while (done !== 1'b1 && cyc < 120) begin
            tick();
            cyc++;
        end
        $display("[TB] done at cycle %0d: q=%h r=%h dz=%b", cyc, quotient, remainder, dz);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
        repeat (3) tick();
        rst = 1'b0;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_tests++; if (quotient !== 32'h0) begin n_fail++; $display("FAIL reset_q: got %h want 0", quotient); end
        n_tests++; if (remainder !== 32'h0) begin n_fail++; $display("FAIL reset_r: got %h want 0", remainder); end
        n_tests++; if (dz !== 1'b0) begin n_fail++; $display("FAIL reset_dz: got %b want 0", dz); end
    endtask

    // Table of unsigned, signed and divide-by-zero vectors with hand-computed results.
    task automatic test_vectors();
        logic        v_sgn [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [31:0] v_a   [7] = '{32'd100, 32'hFFFF_FFFE, 32'hFFFF_FFF9, 32'h0000_0007,
                                   32'h8000_0000, 32'd5, 32'hFFFF_FFFB};
        logic [31:0] v_b   [7] = '{32'd7, 32'h8000_0000, 32'd2, 32'hFFFF_FFFE,
                                   32'hFFFF_FFFF, 32'd0, 32'd0};
        logic [31:0] v_q   [7] = '{32'd14, 32'd1, 32'hFFFF_FFFD, 32'hFFFF_FFFD,
                                   32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] v_r   [7] = '{32'd2, 32'h7FFF_FFFE, 32'hFFFF_FFFF, 32'd1,
                                   32'd0, 32'd5, 32'hFFFF_FFFB};
        logic        v_dz  [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        int cyc;
        for (int i = 0; i < 7; i++) begin
            $display("[TB] vec %0d: signed=%b %h / %h", i, v_sgn[i], v_a[i], v_b[i]);
            launch(v_sgn[i], v_a[i], v_b[i]);
            n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL vec%0d_busy: got %b want 1", i, busy); end
            wait_done(1, cyc);
            n_tests++; if (cyc != 33) begin n_fail++; $display("FAIL vec%0d_latency: got %0d want 33", i, cyc); end
            n_tests++; if (quotient !== v_q[i]) begin n_fail++; $display("FAIL vec%0d_q: got %h want %h", i, quotient, v_q[i]); end
            n_tests++; if (remainder !== v_r[i]) begin n_fail++; $display("FAIL vec%0d_r: got %h want %h", i, remainder, v_r[i]); end
            n_tests++; if (dz !== v_dz[i]) begin n_fail++; $display("FAIL vec%0d_dz: got %b want %b", i, dz, v_dz[i]); end
            tick();
            n_tests++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL vec%0d_idle: got done=%b busy=%b want 0/0", i, done, busy); end
        end
    endtask

    task automatic test_start_ignored();
        int cyc;
        $display("[TB] start ignored: 1000 / 3 with start again at cycle 5");
        launch(1'b0, 32'd1000, 32'd3);
        repeat (4) tick();
        start = 1'b1; dividend = 32'd8; divisor = 32'd2;
        tick();
        start = 1'b0;
        wait_done(6, cyc);
        n_tests++; if (cyc != 33) begin n_fail++; $display("FAIL ign_latency: got %0d want 33", cyc); end
        n_tests++; if (quotient !== 32'd333) begin n_fail++; $display("FAIL ign_q: got %h want %h", quotient, 32'd333); end
        n_tests++; if (remainder !== 32'd1) begin n_fail++; $display("FAIL ign_r: got %h want 1", remainder); end
        repeat (4) tick();
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ign_not_queued: got busy=%b want 0", busy); end
    endtask

    task automatic test_reset_abort();
        int saw_done;
        $display("[TB] reset abort: 77 / 5 with rst at cycle 10");
        launch(1'b0, 32'd77, 32'd5);
        repeat (9) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", busy); end
        n_tests++; if (quotient !== 32'h0 || remainder !== 32'h0 || dz !== 1'b0)
            begin n_fail++; $display("FAIL abort_outputs: got q=%h r=%h dz=%b want 0", quotient, remainder, dz); end
        saw_done = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done === 1'b1) saw_done++;
        end
        n_tests++; if (saw_done != 0) begin n_fail++; $display("FAIL abort_no_done: got %0d pulses want 0", saw_done); end
    endtask

    task automatic test_back_to_back();
        int cyc;
        $display("[TB] back-to-back: FFFFFFFF / 1 then 1000 / 10 accepted at cycle 34");
        launch(1'b0, 32'hFFFF_FFFF, 32'd1);
        wait_done(1, cyc);
        n_tests++; if (cyc != 33) begin n_fail++; $display("FAIL b2b_lat1: got %0d want 33", cyc); end
        n_tests++; if (quotient !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL b2b_q1: got %h want ffffffff", quotient); end
        n_tests++; if (remainder !== 32'h0) begin n_fail++; $display("FAIL b2b_r1: got %h want 0", remainder); end
        start = 1'b1; is_signed = 1'b0; dividend = 32'd1000; divisor = 32'd10;
        tick();
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle34: got busy=%b want 0", busy); end
        tick();
        start = 1'b0; dividend = 32'h5555_5555; divisor = 32'd0;
        n_tests++; if (busy !== 1'b1 || quotient !== 32'hFFFF_FFFF)
            begin n_fail++; $display("FAIL b2b_hold: got busy=%b q=%h want 1/ffffffff", busy, quotient); end
        wait_done(35, cyc);
        n_tests++; if (cyc != 67) begin n_fail++; $display("FAIL b2b_lat2: got %0d want 67", cyc); end
        n_tests++; if (quotient !== 32'd100) begin n_fail++; $display("FAIL b2b_q2: got %h want %h", quotient, 32'd100); end
        n_tests++; if (remainder !== 32'h0 || dz !== 1'b0)
            begin n_fail++; $display("FAIL b2b_r2: got r=%h dz=%b want 0/0", remainder, dz); end
        tick();
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_start_ignored();
        test_reset_abort();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/div_32.md
# div_32

Iterative 32-bit integer divider for the CPU datapath. It is the inverse counterpart of the team's carry-lookahead adder. It performs restoring division by repeated trial subtraction, producing one quotient bit per cycle, and supports both signed (DIV) and unsigned (DIVU) operation. The execute stage starts it, stalls on `busy`, and latches quotient and remainder on `done`.

## Interface
- `WIDTH`, default 32: operand and result width. Only 32 is verified.
- `clk` input 1: rising-edge clock.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: request a division. Sampled only in IDLE.
- `is_signed` input 1: 1 selects two's-complement operation, 0 selects unsigned. Sampled with `start`.
- `dividend` input 32: numerator. Sampled with `start`.
- `divisor` input 32: denominator. Sampled with `start`.
- `busy` output 1: high whenever state is not IDLE.
- `done` output 1: one-cycle pulse. Results are valid in this cycle.
- `quotient` output 32: registered result. Held until the next `done`.
- `remainder` output 32: registered result. Held until the next `done`.
- `div_by_zero` output 1: registered flag, updated together with results.

## Operation
- States:
  - IDLE: waits for `start`.
  - CALC: 32 iterations.
  - DONE: one cycle.
- Transitions:
  - IDLE with `start`=1 goes to CALC.
  - CALC with iteration counter = 31 goes to DONE.
  - DONE always goes to IDLE.
- On accept (IDLE with `start`=1):
  - Latch the operand signs.
  - Load the working quotient with |dividend| in signed mode, or raw dividend in unsigned mode.
  - Latch |divisor| or raw divisor the same way.
  - Clear the 33-bit partial remainder and the 5-bit counter.
- Each CALC cycle:
  - Shift {partial remainder, working quotient} left by 1.
  - Trial-subtract the divisor from the 33-bit partial remainder.
  - If the result is non-negative, keep it and set quotient LSB = 1.
  - Otherwise restore the partial remainder and set quotient LSB = 0.
- On entering DONE, apply sign correction:
  - Quotient is negated iff signed mode and operand signs differ.
  - Remainder takes the sign of the dividend.
- Divide by zero:
  - Detected at accept. Division still runs the full 32 iterations, so latency is fixed.
  - Outputs forced at DONE: `div_by_zero`=1, `quotient`=32'hFFFF_FFFF, `remainder`=original dividend. This holds for both modes.
- Signed overflow: INT_MIN / -1 gives `quotient`=32'h8000_0000 and `remainder`=0. This is the natural abs/negate result; no special case is needed.
- `start` in CALC or DONE is ignored and not queued.
- Operand inputs are don't-care after accept.
- Reset:
  - Next state is IDLE.
  - `busy`=0, `done`=0, `quotient`=0, `remainder`=0, `div_by_zero`=0.
  - A reset mid-operation aborts with no `done` pulse.

## Timing
- Cycle 0: IDLE with `start`=1 (accept edge).
- Cycles 1–32: CALC, `busy`=1.
- Cycle 33: DONE, `busy`=1, `done`=1, results valid.
- Cycle 34: IDLE. A new `start` can be accepted here, giving back-to-back throughput of one division per 34 cycles.
- Fixed latency of 33 cycles from accept to `done`, independent of operand values.
- `quotient`, `remainder` and `div_by_zero` change only on the edge entering DONE (or on reset). They are stable otherwise.
- `busy` and `done` are decoded from the state register only; there is no combinational path from inputs.

## Structure
- Package `div_pkg`:
  - `WIDTH`=32, `ITERS`=32.
  - State enum: IDLE, CALC, DONE.
  - Divide-by-zero quotient constant 32'hFFFF_FFFF.
- Sub-module `div_trial_sub`: combinational 33-bit subtractor (A + ~B + 1) built from 4-bit lookahead slices, returning difference and sign. It is the only arithmetic in the iteration path.
- Pre-negation and post-negation use a shared two's-complement helper function in `div_pkg`.

## Test plan
- Unsigned 100 / 7: start at cycle 0 → `done` at cycle 33, `quotient`=14, `remainder`=2, `div_by_zero`=0.
- Signed -7 / 2 → `quotient`=32'hFFFF_FFFD, `remainder`=32'hFFFF_FFFF.
- Signed 32'h8000_0000 / 32'hFFFF_FFFF → `quotient`=32'h8000_0000, `remainder`=0.
- Unsigned 5 / 0 → `div_by_zero`=1, `quotient`=32'hFFFF_FFFF, `remainder`=5, still at cycle 33.
- Signed -5 / 0 → `div_by_zero`=1, `quotient`=32'hFFFF_FFFF, `remainder`=32'hFFFF_FFFB.
- Second `start` pulsed at cycle 5 is ignored. The first result arrives at cycle 33.
- Separate run: `rst` at cycle 10 → `busy`=0 and outputs = 0 at cycle 11, and no `done` pulse follows.
- Unsigned 32'hFFFF_FFFF / 1 followed immediately by a new start at cycle 34 → first `quotient`=32'hFFFF_FFFF and `remainder`=0, second `done` at cycle 67.
